ofm_writeback: RTL and testbench



---
 rtl/ofm_writeback_pkg.sv | 29 ++
 rtl/ofm_lane_serializer.sv | 44 ++++
 rtl/ofm_writeback.sv | 114 +++++++++++
 tb/tb_ofm_writeback.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ofm_writeback_pkg.sv
// ofm_writeback_pkg: shared sizing helpers and FSM encoding for the OFM write-back stage.
package ofm_writeback_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam int ELEM_WIDTH = 2 * 8;

    function automatic int elem_width(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic int tiles_per_row(input int size, input int lanes);
        return (size + lanes - 1) / lanes;
    endfunction

    function automatic int last_tile_lanes(input int size, input int lanes);
        return (size % lanes == 0) ? lanes : size % lanes;
    endfunction

    function automatic int total_elems(input int size, input int filters);
        return size * size * filters;
    endfunction

endpackage

// File: rtl/ofm_lane_serializer.sv
// ofm_lane_serializer: holds one accepted vector and presents its lanes one per cycle.
module ofm_lane_serializer #(
    parameter int LANES = 16,
    parameter int EW    = 16,
    parameter int LW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic [LANES*EW-1:0]   load_data,
    input  logic [LW-1:0]         load_last,
    output logic [EW-1:0]         lane_data,
    output logic [LW-1:0]         lane_idx,
    output logic                  last_lane
);

    logic [LANES*EW-1:0] vec_q, vec_d;
    logic [LW-1:0]       idx_q, idx_d, lim_q, lim_d;

    // A load on the final lane replaces the vector and restarts at lane 0 without a bubble.
    always_comb begin
        vec_d = load ? load_data : vec_q;
        lim_d = load ? load_last : lim_q;
        idx_d = load ? '0 : advance ? idx_q + LW'(1) : idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
            idx_q <= '0;
            lim_q <= '0;
        end else begin
            vec_q <= vec_d;
            idx_q <= idx_d;
            lim_q <= lim_d;
        end
    end

    assign lane_data = vec_q[idx_q*EW +: EW];
    assign lane_idx  = idx_q;
    assign last_lane = idx_q == lim_q;

endmodule

// File: rtl/ofm_writeback.sv
// ofm_writeback: serialises pooled lane vectors into the sequential OFM RAM write port.
// Build option OFM_WRITEBACK_RELU_EN clamps negative elements to zero before writing.
module ofm_writeback
    import ofm_writeback_pkg::*;
#(
    parameter int SYSTOLIC_SIZE    = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int OFM_SIZE_POOLING = 104,
    parameter int NO_FILTER        = 32,
    parameter int ADDR_WIDTH       = 19
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0] in_data,
    output logic                                ofm_wr_en,
    output logic [ADDR_WIDTH-1:0]               ofm_addr,
    output logic [2*DATA_WIDTH-1:0]             ofm_wr_data,
    output logic                                busy,
    output logic                                done
);

    localparam int EW       = elem_width(DATA_WIDTH);
    localparam int LW       = SYSTOLIC_SIZE > 1 ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam int CW       = $clog2(OFM_SIZE_POOLING + SYSTOLIC_SIZE + 1);
    localparam int TPR      = tiles_per_row(OFM_SIZE_POOLING, SYSTOLIC_SIZE);
    localparam int LAST_N   = last_tile_lanes(OFM_SIZE_POOLING, SYSTOLIC_SIZE);
    localparam logic [CW-1:0] LAST_COL = CW'((TPR - 1) * SYSTOLIC_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(total_elems(OFM_SIZE_POOLING, NO_FILTER) - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         col_q, col_d, col_step;
    logic [EW-1:0]         lane_data, elem;
    logic [LW-1:0]         lane_idx, load_last;
    logic                  last_lane, final_w, accept;

    assign col_step  = (col_q + CW'(SYSTOLIC_SIZE) >= CW'(OFM_SIZE_POOLING)) ? '0 : col_q + CW'(SYSTOLIC_SIZE);
    assign final_w   = addr_q == LAST_ADDR;
    assign accept    = in_valid & in_ready;
    assign load_last = (col_d == LAST_COL) ? LW'(LAST_N - 1) : LW'(SYSTOLIC_SIZE - 1);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        col_d     = col_q;
        in_ready  = 1'b0;
        ofm_wr_en = 1'b0;
        busy      = state_q == ACCEPT || state_q == WRITE;
        done      = state_q == FINISH;
        case (state_q)
            IDLE: if (start) begin
                state_d = ACCEPT;
                addr_d  = '0;
                col_d   = '0;
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) state_d = WRITE;
            end
            WRITE: begin
                ofm_wr_en = 1'b1;
                addr_d    = addr_q + ADDR_WIDTH'(1);
                if (last_lane) begin
                    col_d    = col_step;
                    in_ready = !final_w;
                    state_d  = final_w ? FINISH : in_valid ? WRITE : ACCEPT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
        end
    end

    ofm_lane_serializer #(
        .LANES (SYSTOLIC_SIZE),
        .EW    (EW),
        .LW    (LW)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .advance   (ofm_wr_en),
        .load_data (in_data),
        .load_last (load_last),
        .lane_data (lane_data),
        .lane_idx  (lane_idx),
        .last_lane (last_lane)
    );

`ifdef OFM_WRITEBACK_RELU_EN
    assign elem = lane_data[EW-1] ? '0 : lane_data;
`else
    assign elem = lane_data;
`endif

    assign ofm_addr    = ofm_wr_en ? addr_q : '0;
    assign ofm_wr_data = ofm_wr_en ? elem : '0;

endmodule

// File: tb/tb_ofm_writeback.sv
// tb_ofm_writeback: randomized frames on a small config checked against an address-order model.
module tb_ofm_writeback;

    localparam int S     = 16;
    localparam int DW    = 8;
    localparam int EW    = 2 * DW;
    localparam int P     = 20;
    localparam int NF    = 2;
    localparam int AW    = 10;
    localparam int TOTAL = P * P * NF;
    localparam int TPR   = (P + S - 1) / S;
    localparam int NVEC  = TPR * P * NF;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic          in_ready, ofm_wr_en, busy, done;
    logic [S*EW-1:0] in_data = '0;
    logic [AW-1:0] ofm_addr;
    logic [EW-1:0] ofm_wr_data;

    always #5 clk = ~clk;

    ofm_writeback #(
        .SYSTOLIC_SIZE    (S),
        .DATA_WIDTH       (DW),
        .OFM_SIZE_POOLING (P),
        .NO_FILTER        (NF),
        .ADDR_WIDTH       (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .ofm_wr_en   (ofm_wr_en),
        .ofm_addr    (ofm_addr),
        .ofm_wr_data (ofm_wr_data),
        .busy        (busy),
        .done        (done)
    );

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int            exp_addr[$];
    logic [EW-1:0] exp_data[$];
    int            wr_cnt, done_cnt, dead_cnt;
    bit            last_prev, mon_on = 1'b0;

    function automatic logic [EW-1:0] lane_val(input int kind, input int addr);
        if (kind == 0) return EW'(addr);
        return (addr % 2 != 0) ? 16'd7 : 16'hFFFB;
    endfunction

    function automatic logic [EW-1:0] stored(input logic [EW-1:0] v);
`ifdef OFM_WRITEBACK_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            if (done) begin
                done_cnt++;
                chk("done_after_last", 32'(last_prev), 1);
            end
            last_prev = 1'b0;
            if (ofm_wr_en) begin
                chk("spurious_write", 32'(exp_addr.size() == 0), 0);
                if (exp_addr.size() != 0) begin
                    chk("addr", 32'(ofm_addr), exp_addr.pop_front());
                    chk("data", 32'(ofm_wr_data), 32'(exp_data.pop_front()));
                end
                if (ofm_wr_data == 16'hDEAD) dead_cnt++;
                last_prev = ofm_addr == AW'(TOTAL - 1);
                wr_cnt++;
            end
        end
    end

    task automatic frame(input int kind, input int pct, input bit abort);
        logic [S*EW-1:0] vecs[$];
        logic [S*EW-1:0] v;
        int idx = 0, cyc = 0, c, a;
        bit hs, sp = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < P; r++)
                for (int t = 0; t < TPR; t++) begin
                    v = '0;
                    for (int k = 0; k < S; k++) begin
                        c = t * S + k;
                        a = (f * P + r) * P + c;
                        if (c < P) begin
                            v[k*EW +: EW] = lane_val(kind, a);
                            exp_addr.push_back(a);
                            exp_data.push_back(stored(lane_val(kind, a)));
                        end else
                            v[k*EW +: EW] = 16'hDEAD;
                    end
                    vecs.push_back(v);
                end
        wr_cnt = 0; done_cnt = 0; dead_cnt = 0; last_prev = 1'b0; mon_on = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vecs[0];
        repeat (3) begin
            #1 chk("idle_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        chk("idle_no_write", 32'(wr_cnt), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (idx < NVEC && cyc < 5000) begin
            if (abort && wr_cnt >= 300) break;
            start = abort && wr_cnt >= 100 && !sp;
            if (start) sp = 1'b1;
            in_valid = $urandom_range(99) < pct;
            in_data  = vecs[idx];
            #1 hs = in_valid && in_ready;
            @(negedge clk);
            if (hs) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (abort) begin
            chk("busy_mid_frame", 32'(busy), 1);
            rst_n = 1'b0;
            #1;
            chk("arst_wr_en", 32'(ofm_wr_en), 0);
            chk("arst_addr", 32'(ofm_addr), 0);
            chk("arst_data", 32'(ofm_wr_data), 0);
            chk("arst_busy", 32'(busy), 0);
            chk("arst_ready", 32'(in_ready), 0);
            mon_on = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        chk("vectors_accepted", 32'(idx), NVEC);
        cyc = 0;
        while (done_cnt == 0 && cyc < 50) begin
            @(negedge clk);
            #1 cyc++;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt), 1);
        chk("busy_after", 32'(busy), 0);
        chk("write_count", 32'(wr_cnt), TOTAL);
        chk("leftover", 32'(exp_addr.size()), 0);
        chk("dead_writes", 32'(dead_cnt), 0);
        mon_on = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_wr_en", 32'(ofm_wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(ofm_addr), 0);
        chk("rst_data", 32'(ofm_wr_data), 0);
        rst_n = 1'b1;
        frame(0, 100, 1'b0);
        frame(0, 30, 1'b0);
        frame(0, 60, 1'b1);
        frame(0, 50, 1'b0);
        frame(1, 100, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
